sw_run_sequencer: RTL and testbench
===================================

// Module: sw_run_sequencer
// PURPOSE
//  Run/lap/clear sequencer for the stopwatch counter datapath. It takes the three
//  debounced button levels (run, lap, clear) and detects their rising edges. A 5-state
//  FSM gates the counter's count tick, issues its clear and lap-capture strobes, and
//  drives the status LEDs. It sits between the debounce instances and stop_watch_cnt.
// PARAMETERS
//  CLR_MIN_CYC  16  minimum clk cycles cnt_clr stays high per clear action (>=1)
//  AUTO_STOP    1   1: the tick arriving at cnt_max moves the FSM to STOP; 0: counter wraps
// PORTS
//  clk        in   1  system clock, all state updates on posedge
//  rst        in   1  asynchronous, active-low reset
//  run_key    in   1  debounced run/stop button level
//  lap_key    in   1  debounced lap button level
//  clr_key    in   1  debounced clear button level
//  tick_in    in   1  1-cycle count-rate pulse (e.g. 100 Hz)
//  cnt_max    in   1  high while the counter is at its terminal value
//  cnt_tick   out  1  gated count pulse to the counter (combinational)
//  cnt_clr    out  1  synchronous clear to the counter (registered)
//  lap_load   out  1  1-cycle strobe: display register captures the live count
//  disp_frz   out  1  1 = display shows the lap register, 0 = the live count
//  state_o    out  3  current FSM state encoding (debug/LEDs)
//  led_run    out  1  high in RUN or LAP
//  led_clr    out  1  equals cnt_clr
// BEHAVIOUR
//  Reset: state=IDLE. cnt_clr=0, lap_load=0, disp_frz=0, led_*=0, hold counter=0.
//   The previous-level key registers reset to 1, so a key held through reset release
//   produces no edge.
//  Edge detect: k_prev<=key every cycle; rise = key & ~k_prev. Keys are not
//   resynchronised here.
//  Priority of simultaneous rises: run > lap > clr. Only one is acted on per cycle.
//   The others are dropped.
//  States / encoding: IDLE=0, RUN=1, LAP=2, STOP=3, CLR=4. Codes 5-7 go to IDLE next cycle.
//  IDLE: run rise -> RUN. Lap and clr rises are ignored.
//  RUN : run rise -> STOP. Lap rise -> LAP with lap_load=1 for that one cycle.
//        AUTO_STOP && tick_in && cnt_max -> STOP.
//  LAP : run rise -> STOP (disp_frz drops). Lap rise -> RUN (display goes back to live).
//        The AUTO_STOP rule is the same as in RUN.
//  STOP: run rise -> RUN. Clr rise -> CLR with the hold counter loaded to 1.
//        Lap rise is ignored.
//  CLR : cnt_clr=1. Hold counter saturates at CLR_MIN_CYC.
//        Exit to IDLE on the first cycle with clr_key==0 && hold>=CLR_MIN_CYC.
//        All rises are ignored while in CLR.
//  Latency: a key rise sampled at posedge N changes state, and every registered output,
//   at posedge N+1. cnt_clr, disp_frz and led_run are registered Moore decodes of the
//   next state.
//  cnt_tick = tick_in & (state in {RUN,LAP}) & ~(AUTO_STOP & cnt_max).
//   The terminal tick is never passed on when AUTO_STOP=1. With AUTO_STOP=0 it passes
//   and the counter wraps.
//  disp_frz=1 only in LAP.
//  A second lap rise in LAP returns to RUN and does not re-capture.
//  Reset asserted mid-operation, including mid-CLR, returns immediately to reset values.
//   No partial clear pulse is extended.
// TESTING
//  1. Reset, run pulse -> RUN at edge+1. 10 tick_in -> 10 cnt_tick. Run pulse -> STOP,
//     and later ticks give cnt_tick=0.
//  2. In RUN, lap pulse -> lap_load high exactly 1 cycle and disp_frz=1. Second lap
//     pulse -> RUN, disp_frz=0, no lap_load.
//  3. In STOP, clr held 3 cycles (CLR_MIN_CYC=16) -> cnt_clr high 16 cycles, then IDLE.
//     Clr held 40 cycles -> cnt_clr high until the cycle after release.
//  4. Clr pulse in RUN or IDLE -> no cnt_clr. Run+lap rising in the same cycle in RUN
//     -> STOP and lap_load=0.
//  5. AUTO_STOP=1: cnt_max=1 with tick_in in RUN -> cnt_tick=0 and STOP next edge.
//     AUTO_STOP=0 -> cnt_tick=1 and the FSM stays in RUN.
//  6. rst low during CLR -> cnt_clr=0 asynchronously. Run key held high across rst
//     release -> FSM stays IDLE.

Source files
------------

// File: rtl/sw_run_sequencer.sv
// Stopwatch run/lap/clear sequencer: edge-detects the debounced keys and drives the
// counter's tick gate, clear and lap-capture strobes plus the status LEDs.
module sw_run_sequencer #(
    parameter int CLR_MIN_CYC = 16,
    parameter bit AUTO_STOP   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_key,
    input  logic       lap_key,
    input  logic       clr_key,
    input  logic       tick_in,
    input  logic       cnt_max,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_frz,
    output logic [2:0] state_o,
    output logic       led_run,
    output logic       led_clr
);

    localparam int              HW       = $clog2(CLR_MIN_CYC + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(CLR_MIN_CYC);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_LAP  = 3'd2,
        ST_STOP = 3'd3,
        ST_CLR  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   hold;
    logic [HW-1:0]   hold_nxt;
    logic            lap_go;
    logic            run_prev;
    logic            lap_prev;
    logic            clr_prev;
    logic            run_rise;
    logic            lap_rise;
    logic            clr_rise;
    logic            clr_act;
    logic            auto_hit;
    logic            counting;

    assign run_rise = run_key & ~run_prev;
    assign lap_rise = lap_key & ~lap_prev;
    assign clr_rise = clr_key & ~clr_prev;
    // Only the highest-priority rise in a cycle is acted on; the others are dropped.
    assign clr_act  = clr_rise & ~run_rise & ~lap_rise;
    assign auto_hit = AUTO_STOP & tick_in & cnt_max;

    assign counting = (state == ST_RUN) || (state == ST_LAP);
    assign cnt_tick = tick_in & counting & ~(AUTO_STOP & cnt_max);
    assign state_o  = state;
    assign led_clr  = cnt_clr;

    always_comb begin
        state_nxt = ST_IDLE;
        hold_nxt  = '0;
        lap_go    = 1'b0;
        case (state)
            ST_IDLE: state_nxt = run_rise ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (run_rise) begin
                    state_nxt = ST_STOP;
                end else if (lap_rise) begin
                    state_nxt = ST_LAP;
                    lap_go    = 1'b1;
                end else if (auto_hit) begin
                    state_nxt = ST_STOP;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_LAP: begin
                if (run_rise || (!lap_rise && auto_hit)) begin
                    state_nxt = ST_STOP;
                end else if (lap_rise) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_LAP;
                end
            end
            ST_STOP: begin
                if (run_rise) begin
                    state_nxt = ST_RUN;
                end else if (clr_act) begin
                    state_nxt = ST_CLR;
                    hold_nxt  = HW'(1);
                end else begin
                    state_nxt = ST_STOP;
                end
            end
            ST_CLR: begin
                // Clear lasts at least CLR_MIN_CYC cycles and until the key is released.
                if (!clr_key && (hold >= HOLD_MAX)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_CLR;
                    hold_nxt  = (hold < HOLD_MAX) ? hold + HW'(1) : hold;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs are Moore decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            hold     <= '0;
            run_prev <= 1'b1;
            lap_prev <= 1'b1;
            clr_prev <= 1'b1;
            cnt_clr  <= 1'b0;
            lap_load <= 1'b0;
            disp_frz <= 1'b0;
            led_run  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            run_prev <= run_key;
            lap_prev <= lap_key;
            clr_prev <= clr_key;
            cnt_clr  <= (state_nxt == ST_CLR);
            lap_load <= lap_go;
            disp_frz <= (state_nxt == ST_LAP);
            led_run  <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
        end
    end

endmodule

// File: tb/tb_sw_run_sequencer.sv
// Directed bench for sw_run_sequencer: one instance with AUTO_STOP=1, one with AUTO_STOP=0.
module tb_sw_run_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_key, lap_key, clr_key, tick_in, cnt_max;
    logic       cnt_tick, cnt_clr, lap_load, disp_frz, led_run, led_clr;
    logic [2:0] state_o;
    logic       cnt_tick_w, cnt_clr_w, lap_load_w, disp_frz_w, led_run_w, led_clr_w;
    logic [2:0] state_w;

    int n_vec = 0;
    int n_bad = 0;
    int n;

    always #5 clk = ~clk;

    sw_run_sequencer #(.CLR_MIN_CYC(16), .AUTO_STOP(1'b1)) dut (
        .clk(clk), .rst(rst), .run_key(run_key), .lap_key(lap_key), .clr_key(clr_key),
        .tick_in(tick_in), .cnt_max(cnt_max), .cnt_tick(cnt_tick), .cnt_clr(cnt_clr),
        .lap_load(lap_load), .disp_frz(disp_frz), .state_o(state_o), .led_run(led_run),
        .led_clr(led_clr)
    );

    sw_run_sequencer #(.CLR_MIN_CYC(16), .AUTO_STOP(1'b0)) dut_w (
        .clk(clk), .rst(rst), .run_key(run_key), .lap_key(lap_key), .clr_key(clr_key),
        .tick_in(tick_in), .cnt_max(cnt_max), .cnt_tick(cnt_tick_w), .cnt_clr(cnt_clr_w),
        .lap_load(lap_load_w), .disp_frz(disp_frz_w), .state_o(state_w), .led_run(led_run_w),
        .led_clr(led_clr_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run_key = 1'b1;
        step();
        run_key = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        run_key = 1'b0; lap_key = 1'b0; clr_key = 1'b0; tick_in = 1'b0; cnt_max = 1'b0;
        repeat (3) step();
        chk("rst_state", state_o, 0);
        chk("rst_clr", cnt_clr, 0);
        chk("rst_lap", lap_load, 0);
        chk("rst_frz", disp_frz, 0);
        chk("rst_led_run", led_run, 0);
        chk("rst_led_clr", led_clr, 0);
        rst = 1'b1;
        step(); step();

        // run start, ticks, stop
        run_key = 1'b1;
        step();
        chk("run_state", state_o, 1);
        chk("run_led", led_run, 1);
        run_key = 1'b0;
        step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick_in = 1'b1;
            #1;
            if (cnt_tick) n++;
            step();
            tick_in = 1'b0;
            step();
        end
        chk("tick_count", n, 10);
        run_key = 1'b1;
        step();
        chk("stop_state", state_o, 3);
        chk("stop_led", led_run, 0);
        run_key = 1'b0;
        tick_in = 1'b1;
        #1;
        chk("stop_tick", cnt_tick, 0);
        tick_in = 1'b0;
        step();

        // lap capture and return
        pulse_run();
        chk("rerun_state", state_o, 1);
        lap_key = 1'b1;
        step();
        chk("lap_state", state_o, 2);
        chk("lap_load_hi", lap_load, 1);
        chk("lap_frz", disp_frz, 1);
        lap_key = 1'b0;
        step();
        chk("lap_load_1cyc", lap_load, 0);
        chk("lap_frz_hold", disp_frz, 1);
        tick_in = 1'b1;
        #1;
        chk("lap_tick", cnt_tick, 1);
        tick_in = 1'b0;
        lap_key = 1'b1;
        step();
        chk("lap2_state", state_o, 1);
        chk("lap2_frz", disp_frz, 0);
        chk("lap2_noload", lap_load, 0);
        lap_key = 1'b0;
        step();

        // clr ignored in RUN, run+lap together in RUN
        clr_key = 1'b1;
        step();
        chk("clr_in_run", cnt_clr, 0);
        chk("clr_in_run_st", state_o, 1);
        clr_key = 1'b0;
        step();
        run_key = 1'b1; lap_key = 1'b1;
        step();
        chk("runlap_state", state_o, 3);
        chk("runlap_load", lap_load, 0);
        run_key = 1'b0; lap_key = 1'b0;
        step();
        chk("runlap_load2", lap_load, 0);
        chk("runlap_frz", disp_frz, 0);

        // short clear press: minimum length
        clr_key = 1'b1;
        step();
        chk("clr_state", state_o, 4);
        chk("clr_led", led_clr, 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) clr_key = 1'b0;
            step();
            if (cnt_clr) n++;
        end
        chk("clr_short_len", n, 16);
        chk("clr_short_end", state_o, 0);

        // long clear press: held past the minimum
        pulse_run();
        pulse_run();
        chk("stop_again", state_o, 3);
        clr_key = 1'b1;
        step();
        n = 1;
        for (int i = 0; i < 60; i++) begin
            if (i == 39) clr_key = 1'b0;
            step();
            if (cnt_clr) n++;
        end
        chk("clr_long_len", n, 40);
        chk("clr_long_end", state_o, 0);
        chk("clr_long_led", led_clr, 0);

        // clr ignored in IDLE
        clr_key = 1'b1;
        step();
        chk("clr_in_idle", cnt_clr, 0);
        chk("clr_in_idle_st", state_o, 0);
        clr_key = 1'b0;
        step();

        // terminal tick with and without auto-stop
        pulse_run();
        cnt_max = 1'b1;
        tick_in = 1'b1;
        #1;
        chk("auto_tick", cnt_tick, 0);
        chk("wrap_tick", cnt_tick_w, 1);
        step();
        chk("auto_state", state_o, 3);
        chk("wrap_state", state_w, 1);
        tick_in = 1'b0;
        cnt_max = 1'b0;
        step();

        // async reset mid-clear, run held through reset release
        clr_key = 1'b1;
        step();
        chk("pre_rst_clr", cnt_clr, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_clr", cnt_clr, 0);
        chk("async_rst_state", state_o, 0);
        clr_key = 1'b0;
        run_key = 1'b1;
        step();
        rst = 1'b1;
        step(); step();
        chk("held_run_idle", state_o, 0);
        chk("held_run_w_idle", state_w, 0);
        run_key = 1'b0;
        step();
        run_key = 1'b1;
        step();
        chk("post_rst_run", state_o, 1);
        run_key = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
